frame_buffer_loader: RTL and testbench

//  Streams one frame of pixels from an upstream FIFO/decoder into a multi-buffer image BRAM.

---
 rtl/frame_buffer_loader.sv | 172 +++++++++++++++++
 tb/tb_frame_buffer_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_loader.sv
`default_nettype none
//============================================================================
// Module   : frame_buffer_loader
// Purpose  : Streams one frame of pixels from a ready/valid source into a
//            multi-buffer frame BRAM, with optional RGB->gray packing.
// Revision : 1.0 - initial release
//============================================================================
module frame_buffer_loader #(
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 720,
  parameter int IMAGE_SIZE  = WIDTH * HEIGHT,
  parameter int NUM_BUFFERS = 2,
  parameter int PIXEL_BITS  = 24,
  parameter int GRAY_MODE   = 1,
  parameter int OUT_BITS    = (GRAY_MODE != 0) ? 8 : PIXEL_BITS,
  parameter int ADDR_BITS   = $clog2(NUM_BUFFERS * IMAGE_SIZE),
  parameter int BUF_BITS    = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_BUFFERS-1:0] buf_busy,
  input  logic                   in_valid,
  input  logic [PIXEL_BITS-1:0]  in_data,
  output logic                   in_ready,
  output logic                   bram_wr_en,
  output logic [ADDR_BITS-1:0]   bram_wr_addr,
  output logic [OUT_BITS-1:0]    bram_wr_data,
  output logic                   busy,
  output logic [BUF_BITS-1:0]    wr_buf,
  output logic [BUF_BITS-1:0]    done_buf,
  output logic                   load_finished
);

  localparam int X_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [X_BITS-1:0]    C_X_LAST     = X_BITS'(WIDTH - 1);
  localparam logic [Y_BITS-1:0]    C_Y_LAST     = Y_BITS'(HEIGHT - 1);
  localparam logic [BUF_BITS-1:0]  C_BUF_LAST   = BUF_BITS'(NUM_BUFFERS - 1);
  localparam logic [ADDR_BITS-1:0] C_WIDTH      = ADDR_BITS'(WIDTH);
  localparam logic [ADDR_BITS-1:0] C_IMAGE_SIZE = ADDR_BITS'(IMAGE_SIZE);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BUF = 2'd1,
    S_LOAD     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [X_BITS-1:0]     r_x;
  logic [Y_BITS-1:0]     r_y;
  logic [BUF_BITS-1:0]   r_wr_buf;
  logic [BUF_BITS-1:0]   r_done_buf;
  logic                  r_wr_en;
  logic [ADDR_BITS-1:0]  r_wr_addr;
  logic [OUT_BITS-1:0]   r_wr_data;
  logic                  r_load_finished;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_commit;
  logic                  w_commit_last;
  logic                  w_buf_free;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [OUT_BITS-1:0]   w_pixel;

  assign in_ready      = (r_state == S_LOAD);
  assign busy          = (r_state != S_IDLE);
  assign bram_wr_en    = r_wr_en;
  assign bram_wr_addr  = r_wr_addr;
  assign bram_wr_data  = r_wr_data;
  assign wr_buf        = r_wr_buf;
  assign done_buf      = r_done_buf;
  assign load_finished = r_load_finished;

  assign w_accept      = in_valid && in_ready;
  assign w_last        = w_accept && (r_x == C_X_LAST) && (r_y == C_Y_LAST);
  // A beat accepted in the same cycle as abort is dropped.
  assign w_commit      = w_accept && !abort;
  assign w_commit_last = w_last && !abort;
  assign w_buf_free    = !buf_busy[r_wr_buf];

  assign w_addr = ADDR_BITS'(r_wr_buf) * C_IMAGE_SIZE
                + ADDR_BITS'(r_y) * C_WIDTH
                + ADDR_BITS'(r_x);

  if (GRAY_MODE != 0) begin : g_gray
    logic [9:0] w_sum;
    // (R + 2G + B) >> 2, truncated
    assign w_sum   = {2'b00, in_data[23:16]}
                   + {1'b0, in_data[15:8], 1'b0}
                   + {2'b00, in_data[7:0]};
    assign w_pixel = OUT_BITS'(w_sum >> 2);
  end else begin : g_pass
    assign w_pixel = in_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_next = w_buf_free ? S_LOAD : S_WAIT_BUF;
        end
      end
      S_WAIT_BUF: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_buf_free) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort || w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x             <= '0;
      r_y             <= '0;
      r_wr_buf        <= '0;
      r_done_buf      <= '0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_load_finished <= 1'b0;
    end else begin
      r_wr_en         <= w_commit;
      r_load_finished <= w_commit_last;
      if (w_commit) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_pixel;
      end

      // Raster position is only meaningful while loading; restart from origin otherwise.
      if (r_state != S_LOAD) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_accept) begin
        if (r_x == C_X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == C_Y_LAST) ? '0 : r_y + Y_BITS'(1);
        end else begin
          r_x <= r_x + X_BITS'(1);
        end
      end

      if (w_commit_last) begin
        r_done_buf <= r_wr_buf;
        r_wr_buf   <= (r_wr_buf == C_BUF_LAST) ? '0 : r_wr_buf + BUF_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_loader.sv
`default_nettype none
//============================================================================
// Module   : tb_frame_buffer_loader
// Purpose  : Self-checking bench for frame_buffer_loader (4x2, 2 buffers, gray).
// Revision : 1.0 - initial release
//============================================================================
module tb_frame_buffer_loader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NB = 2;
  localparam int PB = 24;
  localparam int OB = 8;
  localparam int AB = 4;
  localparam int FS = W * H;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [NB-1:0] buf_busy;
  logic          in_valid;
  logic [PB-1:0] in_data;
  logic          in_ready;
  logic          bram_wr_en;
  logic [AB-1:0] bram_wr_addr;
  logic [OB-1:0] bram_wr_data;
  logic          busy;
  logic [0:0]    wr_buf;
  logic [0:0]    done_buf;
  logic          load_finished;

  always #5 clock = ~clock;

  frame_buffer_loader #(
    .WIDTH(W), .HEIGHT(H), .NUM_BUFFERS(NB), .PIXEL_BITS(PB), .GRAY_MODE(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .buf_busy(buf_busy), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data), .busy(busy), .wr_buf(wr_buf),
    .done_buf(done_buf), .load_finished(load_finished)
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [OB-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  gray;
  } vec_t;

  wr_t  act_q[$];
  wr_t  exp_q[$];
  int   fin_q[$];
  vec_t vecs[FS];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_buf = 0;
  int   exp_done = 0;
  bit   chained;

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (bram_wr_en) act_q.push_back('{bram_wr_addr, bram_wr_data, cyc});
      if (load_finished) fin_q.push_back(cyc);
    end
  end

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
    s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 4);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    act_q.delete();
    exp_q.delete();
    fin_q.delete();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // valid_pct < 0 toggles in_valid every cycle.
  // end_mode: 0 full frame, 1 abort after n_acc, 2 stop after n_acc, 3 full + start on done.
  task automatic run_frame(input int valid_pct, input int n_acc, input int end_mode,
                           input bit use_table, input bit rand_start);
    int acc = 0;
    int budget = 0;
    while (acc < n_acc && budget < 200) begin
      if (valid_pct < 0) in_valid = (budget % 2 == 0);
      else in_valid = ($urandom_range(0, 99) < valid_pct);
      in_data = use_table ? vecs[acc].pix : 24'($urandom);
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back('{AB'(exp_buf * FS + acc),
                          use_table ? vecs[acc].gray : gray_of(in_data), cyc + 1});
        acc++;
      end
      tick();
      budget++;
    end
    check("beats_accepted", acc, n_acc);
    start = 1'b0;
    in_valid = 1'b0;
    if (end_mode == 1) begin
      in_valid = 1'b1;
      in_data = 24'($urandom);
      abort = 1'b1;
      check("ready_on_abort", in_ready, 1);
      tick();
      abort = 1'b0;
      in_valid = 1'b0;
      check("busy_after_abort", busy, 0);
      check("no_finish_abort", load_finished, 0);
    end else if (end_mode == 0 || end_mode == 3) begin
      check("ready_drop", in_ready, 0);
      check("finish_pulse", load_finished, 1);
      if (end_mode == 3) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_on_finish", busy, 1);
      end
    end
  endtask

  task automatic advance_model();
    exp_done = exp_buf;
    exp_buf  = (exp_buf + 1) % NB;
  endtask

  task automatic compare(input bit expect_fin, input bit exp_busy);
    tick();
    tick();
    check("write_count", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      check("wr_addr", act_q[i].addr, exp_q[i].addr);
      check("wr_data", act_q[i].data, exp_q[i].data);
      check("wr_cycle", act_q[i].cyc, exp_q[i].cyc);
    end
    check("finish_count", fin_q.size(), expect_fin);
    if (expect_fin && fin_q.size() == 1 && exp_q.size() > 0)
      check("finish_cycle", fin_q[0], exp_q[exp_q.size()-1].cyc);
    check("done_buf", done_buf, exp_done);
    check("wr_buf", wr_buf, exp_buf);
    check("busy", busy, exp_busy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, bram_wr_en, 0);
    check({tag, "_wr_addr"}, bram_wr_addr, 0);
    check({tag, "_wr_data"}, bram_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wr_buf"}, wr_buf, 0);
    check({tag, "_done_buf"}, done_buf, 0);
    check({tag, "_finished"}, load_finished, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{24'hFF8040, 8'h8F};
    vecs[1] = '{24'hFFFFFF, 8'hFF};
    vecs[2] = '{24'h000000, 8'h00};
    vecs[3] = '{24'h010101, 8'h01};
    vecs[4] = '{24'h00FF00, 8'h7F};
    vecs[5] = '{24'hFF00FF, 8'h7F};
    vecs[6] = '{24'h123456, 8'h34};
    vecs[7] = '{24'h030303, 8'h03};

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; buf_busy = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Table frame, back-to-back: addr 0..7 with known gray values.
    clear_logs();
    start_pulse();
    run_frame(100, FS, 0, 1'b1, 1'b0);
    advance_model();
    compare(1'b1, 1'b0);

    // Second buffer, then a held buffer forces WAIT_BUF.
    clear_logs();
    start_pulse();
    run_frame(100, FS, 0, 1'b0, 1'b0);
    advance_model();
    compare(1'b1, 1'b0);

    clear_logs();
    buf_busy = NB'(1 << exp_buf);
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 24'($urandom);
      check("wait_ready", in_ready, 0);
      check("wait_busy", busy, 1);
      tick();
    end
    in_valid = 1'b0;
    check("wait_no_writes", act_q.size(), 0);
    buf_busy = '0;
    run_frame(100, FS, 0, 1'b0, 1'b0);
    advance_model();
    compare(1'b1, 1'b0);

    // Alternating valid: contiguous addresses, no writes on stalls.
    clear_logs();
    start_pulse();
    run_frame(-1, FS, 0, 1'b0, 1'b0);
    advance_model();
    compare(1'b1, 1'b0);

    // Abort after three beats, then reload the same buffer.
    clear_logs();
    start_pulse();
    run_frame(100, 3, 1, 1'b0, 1'b0);
    compare(1'b0, 1'b0);
    clear_logs();
    start_pulse();
    run_frame(100, FS, 0, 1'b0, 1'b0);
    advance_model();
    compare(1'b1, 1'b0);

    // Random throughput and stray starts during LOAD.
    chained = 1'b0;
    for (int f = 0; f < 6; f++) begin
      int mode;
      mode = (f % 2 == 0) ? 3 : 0;
      clear_logs();
      if (!chained) start_pulse();
      run_frame(int'($urandom_range(30, 100)), FS, mode, 1'b0, 1'b1);
      advance_model();
      compare(1'b1, mode == 3);
      chained = (mode == 3);
    end

    // Asynchronous reset in the middle of a load.
    clear_logs();
    start_pulse();
    run_frame(100, 5, 2, 1'b0, 1'b0);
    check("write_before_reset", bram_wr_en, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    exp_buf = 0;
    exp_done = 0;
    clear_logs();
    start_pulse();
    run_frame(100, FS, 0, 1'b0, 1'b0);
    advance_model();
    compare(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
